// File: rtl/serdes_pulse_generator.sv
// Pulse word generator for an OSERDES output stage. A trigger schedules one pulse
// at a programmable coarse + fine offset with bit-period resolution.
module serdes_pulse_generator #(
  parameter  int DATA_WIDTH  = 4,
  parameter  int DELAY_WIDTH = 16,
  parameter  int WIDTH_WIDTH = 16,
  localparam int FINE_WIDTH  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic                   i_parallel_clk,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic                   i_trigger,
  input  logic [DELAY_WIDTH-1:0] i_coarse_delay,
  input  logic [FINE_WIDTH-1:0]  i_fine_delay,
  input  logic [WIDTH_WIDTH-1:0] i_pulse_width,
  output logic [DATA_WIDTH-1:0]  o_data_out,
  output logic                   o_busy,
  output logic                   o_trigger_dropped
);

  // One spare bit over coarse*DATA_WIDTH + width keeps the offset arithmetic wrap-free.
  localparam int OFS_WIDTH = DELAY_WIDTH + WIDTH_WIDTH + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [OFS_WIDTH-1:0]   r_start;
  logic [OFS_WIDTH-1:0]   r_end;
  logic [OFS_WIDTH-1:0]   r_base;
  logic [DATA_WIDTH-1:0]  r_data_out;
  logic                   r_trigger_dropped;

  logic [FINE_WIDTH-1:0]  w_fine_sat;
  logic [OFS_WIDTH-1:0]   w_start;
  logic [OFS_WIDTH-1:0]   w_end;
  logic [OFS_WIDTH-1:0]   w_next_base;
  logic                   w_busy;
  logic                   w_accept;
  logic                   w_last;
  logic [DATA_WIDTH-1:0]  w_word;

  assign w_busy = (r_state == RUN);

  // Out-of-range fine delays clamp to the last bit of the word.
  always_comb begin
    w_fine_sat = i_fine_delay;
    if (int'(i_fine_delay) >= DATA_WIDTH)
      w_fine_sat = FINE_WIDTH'(DATA_WIDTH - 1);
  end

  assign w_start     = OFS_WIDTH'(i_coarse_delay) * OFS_WIDTH'(DATA_WIDTH) + OFS_WIDTH'(w_fine_sat);
  assign w_end       = w_start + OFS_WIDTH'(i_pulse_width);
  assign w_next_base = r_base + OFS_WIDTH'(DATA_WIDTH);
  assign w_accept    = i_trigger && i_enable && !w_busy && (i_pulse_width != '0);
  // The current word is the last one holding pulse bits when the next word starts at or past E.
  assign w_last      = (w_next_base >= r_end);

  // State register
  always_ff @(posedge i_parallel_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  // Next-state logic
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: if (w_accept) w_next_state = RUN;
      RUN:  if (w_last)   w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Output logic: the word for base B, forced to zero outside RUN
  always_comb begin
    w_word = '0;
    if (r_state == RUN) begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        w_word[i] = ((r_base + OFS_WIDTH'(i)) >= r_start) &&
                    ((r_base + OFS_WIDTH'(i)) <  r_end);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge i_parallel_clk) begin
    if (i_reset) begin
      r_start           <= '0;
      r_end             <= '0;
      r_base            <= '0;
      r_data_out        <= '0;
      r_trigger_dropped <= 1'b0;
    end else begin
      r_data_out        <= w_word;
      r_trigger_dropped <= i_trigger && i_enable && w_busy;
      if (w_accept) begin
        r_start <= w_start;
        r_end   <= w_end;
        r_base  <= '0;
      end else if (w_busy) begin
        r_base  <= w_next_base;
      end
    end
  end

  assign o_data_out        = r_data_out;
  assign o_busy            = w_busy;
  assign o_trigger_dropped = r_trigger_dropped;

endmodule

// File: doc/serdes_pulse_generator.md
# serdes_pulse_generator

Produces DATA_WIDTH-bit parallel words that describe one output pulse with bit-period resolution. Each word feeds the parallel input of the OSERDES output stage, and the output stage shifts bit 0 out first. A single-cycle trigger starts the pulse after a programmable delay: a coarse part in parallel-clock cycles plus a fine part in bit periods. The pulse width is programmable in bit periods. The block sits directly upstream of the output serializer in each event-receiver trigger output channel and runs entirely in the parallel-clock domain.

## Interface
- DATA_WIDTH, 4, bits per parallel word / serialization factor; legal 2..8
- DELAY_WIDTH, 16, width of coarseDelay in parallel-clock cycles
- WIDTH_WIDTH, 16, width of pulseWidth in bit periods
- parallelClk  in  1  the single clock (parallel-side clock)
- reset  in  1  synchronous, active-high
- enable  in  1  when low, triggers are ignored; an in-progress pulse still completes
- trigger  in  1  single-cycle start strobe
- coarseDelay  in  DELAY_WIDTH  delay in whole words (C)
- fineDelay  in  clog2(DATA_WIDTH)  delay in bit periods within a word (F); values >= DATA_WIDTH saturate to DATA_WIDTH-1
- pulseWidth  in  WIDTH_WIDTH  pulse length in bit periods (W)
- dataOut  out  DATA_WIDTH  registered word to the serializer; bit 0 is sent first
- busy  out  1  a pulse is pending or in progress
- triggerDropped  out  1  one-cycle flag: a trigger arrived while busy

## Operation
- The pulse start offset is S = C*DATA_WIDTH + F, in bit periods. The pulse end is E = S + W, exclusive.
- The internal offset arithmetic is DELAY_WIDTH + WIDTH_WIDTH + 1 bits wide, so it never wraps.
- Acceptance: a trigger is accepted when trigger=1, enable=1, busy=0 and W != 0.
  - On acceptance, C, F and W are latched. Input changes afterwards have no effect on the current pulse.
  - A trigger with W=0 is ignored. busy stays 0 and triggerDropped stays 0.
- A trigger with enable=1 while busy=1 is discarded and triggerDropped pulses high for one cycle. The running pulse is unaffected.
- A trigger with enable=0 is discarded silently (no triggerDropped).
- State machine:
  - IDLE -> RUN on acceptance.
  - RUN -> IDLE on the edge that loads the last word with any bit inside [S,E).
- Word generation in RUN:
  - The word base B starts at 0 and increases by DATA_WIDTH per cycle.
  - dataOut[i] = 1 iff S <= B+i < E.
- In IDLE, dataOut = 0.

## Timing
- Reset values: dataOut=0, busy=0, triggerDropped=0, state=IDLE, B=0. Reset mid-pulse aborts it, and dataOut is 0 from the next edge.
- Latency: for a trigger sampled at edge k, the word with B=0 is on dataOut after edge k+1. The word with B=j*DATA_WIDTH is on dataOut after edge k+1+j.
- Leading zero words (B < S rounded down to a word boundary) are driven as 0 while busy stays high.
- busy:
  - Rises on the accepting edge.
  - Falls on the edge that loads the last word containing pulse bits.
  - busy is therefore low during the cycle that final word is displayed.
- Back-to-back: a trigger in the final-word cycle is accepted. With C=0 and F=0, its first word follows immediately, so the serial output can be continuous.
- triggerDropped is registered. It is high for exactly the cycle after the offending trigger edge.
- No combinational path exists from any input to any output.

## Test plan
- DATA_WIDTH=4, C=0, F=0, W=4, trigger at edge k -> dataOut=4'b1111 for one cycle after edge k+1, then 0; busy high for exactly one cycle.
- C=2, F=1, W=6 -> dataOut: 0000, 0000, 1110, 0111 after edges k+1..k+4, then 0; busy falls at edge k+4.
- C=0, F=3, W=9 -> 1000, 1111, 1111, then 0; the total count of high bits is 9.
- W=4 running, second trigger at edge k+1 with enable=1 -> triggerDropped=1 for one cycle, output identical to scenario 1. Same stimulus with enable=0 -> no triggerDropped.
- W=0 trigger -> busy=0, dataOut=0, no triggerDropped. C=3 trigger with enable=0 -> nothing happens.
- Reset asserted during the second 1111 word of W=40 -> dataOut=0 and busy=0 after the next edge. A new trigger issued the cycle after reset is released produces a correct pulse.
